apb2axi: RTL and testbench



---
 rtl/apb2axi_pkg.sv | 9 +
 rtl/apb2axi.sv | 187 ++++++++++++++++++
 tb/tb_apb2axi.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: shared FSM state, AXI response codes and burst encoding for the APB-to-AXI4 bridge
package apb2axi_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
endpackage

// File: rtl/apb2axi.sv
// apb2axi: single-outstanding APB completer to AXI4 single-beat manager; APB2AXI_APB4_EN adds PSTRB/PPROT
module apb2axi
  import apb2axi_pkg::*;
#(
  parameter int          AXI4_ADDRESS_WIDTH = 32,
  parameter int          AXI4_DATA_WIDTH    = 32,
  parameter int          AXI4_ID_WIDTH      = 16,
  parameter int          AXI4_USER_WIDTH    = 10,
  parameter int          APB_ADDR_WIDTH     = 32,
  parameter int unsigned AXI_ID             = 0
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            PSEL,
  input  logic                            PENABLE,
  input  logic                            PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0]       PADDR,
  input  logic [AXI4_DATA_WIDTH-1:0]      PWDATA,
`ifdef APB2AXI_APB4_EN
  input  logic [AXI4_DATA_WIDTH/8-1:0]    PSTRB,
  input  logic [2:0]                      PPROT,
`endif
  output logic [AXI4_DATA_WIDTH-1:0]      PRDATA,
  output logic                            PREADY,
  output logic                            PSLVERR,
  output logic [AXI4_ID_WIDTH-1:0]        AWID,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR,
  output logic [7:0]                      AWLEN,
  output logic [2:0]                      AWSIZE,
  output logic [1:0]                      AWBURST,
  output logic                            AWLOCK,
  output logic [3:0]                      AWCACHE,
  output logic [2:0]                      AWPROT,
  output logic [3:0]                      AWREGION,
  output logic [3:0]                      AWQOS,
  output logic [AXI4_USER_WIDTH-1:0]      AWUSER,
  output logic                            AWVALID,
  input  logic                            AWREADY,
  output logic [AXI4_DATA_WIDTH-1:0]      WDATA,
  output logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB,
  output logic                            WLAST,
  output logic [AXI4_USER_WIDTH-1:0]      WUSER,
  output logic                            WVALID,
  input  logic                            WREADY,
  input  logic [AXI4_ID_WIDTH-1:0]        BID,
  input  logic [1:0]                      BRESP,
  input  logic [AXI4_USER_WIDTH-1:0]      BUSER,
  input  logic                            BVALID,
  output logic                            BREADY,
  output logic [AXI4_ID_WIDTH-1:0]        ARID,
  output logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR,
  output logic [7:0]                      ARLEN,
  output logic [2:0]                      ARSIZE,
  output logic [1:0]                      ARBURST,
  output logic                            ARLOCK,
  output logic [3:0]                      ARCACHE,
  output logic [2:0]                      ARPROT,
  output logic [3:0]                      ARREGION,
  output logic [3:0]                      ARQOS,
  output logic [AXI4_USER_WIDTH-1:0]      ARUSER,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  input  logic [AXI4_ID_WIDTH-1:0]        RID,
  input  logic [AXI4_DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                      RRESP,
  input  logic                            RLAST,
  input  logic [AXI4_USER_WIDTH-1:0]      RUSER,
  input  logic                            RVALID,
  output logic                            RREADY
);
  localparam int STRB_W = AXI4_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = 3'($clog2(STRB_W));
  state_e state_q, state_d;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [AXI4_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0] strb_q, strb_d, strb_in;
  logic [2:0] prot_q, prot_d, prot_in;
  logic [1:0] resp_q, resp_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic unused;
  assign unused = ^{BID, BUSER, RID, RLAST, RUSER};
`ifdef APB2AXI_APB4_EN
  assign strb_in = PSTRB;
  assign prot_in = PPROT;
`else
  assign strb_in = '1;
  assign prot_in = 3'b000;
`endif
  // Next-state and captured-field logic; AW and W handshakes are tracked independently
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    strb_d = strb_q;
    prot_d = prot_q;
    resp_d = resp_q;
    aw_done_d = aw_done_q;
    w_done_d = w_done_q;
    case (state_q)
      IDLE: if (PSEL && !PENABLE) begin
        addr_d = AXI4_ADDRESS_WIDTH'(PADDR);
        wdata_d = PWDATA;
        strb_d = strb_in;
        prot_d = prot_in;
        rdata_d = '0;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
        state_d = PWRITE ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | AWREADY;
        w_done_d = w_done_q | WREADY;
        state_d = (aw_done_d && w_done_d) ? WR_RESP : WR_REQ;
      end
      WR_RESP: if (BVALID) begin
        resp_d = BRESP;
        state_d = DONE;
      end
      RD_REQ: state_d = ARREADY ? RD_RESP : RD_REQ;
      RD_RESP: if (RVALID) begin
        rdata_d = RDATA;
        resp_d = RRESP;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and captured-field registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q <= '0;
      prot_q <= '0;
      resp_q <= RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      strb_q <= strb_d;
      prot_q <= prot_d;
      resp_q <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
    end
  end
  assign PREADY = state_q == DONE;
  assign PSLVERR = PREADY && resp_q[1];
  assign PRDATA = rdata_q;
  assign AWVALID = state_q == WR_REQ && !aw_done_q;
  assign WVALID = state_q == WR_REQ && !w_done_q;
  assign BREADY = state_q == WR_RESP;
  assign ARVALID = state_q == RD_REQ;
  assign RREADY = state_q == RD_RESP;
  assign AWID = AXI4_ID_WIDTH'(AXI_ID);
  assign AWADDR = addr_q;
  assign AWLEN = 8'd0;
  assign AWSIZE = SIZE;
  assign AWBURST = BURST_INCR;
  assign AWLOCK = 1'b0;
  assign AWCACHE = 4'd0;
  assign AWPROT = prot_q;
  assign AWREGION = 4'd0;
  assign AWQOS = 4'd0;
  assign AWUSER = '0;
  assign WDATA = wdata_q;
  assign WSTRB = strb_q;
  assign WLAST = 1'b1;
  assign WUSER = '0;
  assign ARID = AXI4_ID_WIDTH'(AXI_ID);
  assign ARADDR = addr_q;
  assign ARLEN = 8'd0;
  assign ARSIZE = SIZE;
  assign ARBURST = BURST_INCR;
  assign ARLOCK = 1'b0;
  assign ARCACHE = 4'd0;
  assign ARPROT = prot_q;
  assign ARREGION = 4'd0;
  assign ARQOS = 4'd0;
  assign ARUSER = '0;
endmodule

// File: tb/tb_apb2axi.sv
// tb_apb2axi: directed and randomized APB accesses against a timing/memory reference model; honours APB2AXI_APB4_EN
module tb_apb2axi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = 0, pwdata = 0;
  logic [3:0] pstrb = 4'hf;
  logic [2:0] pprot = 3'd0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [15:0] awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst;
  logic awlock, arlock, wlast;
  logic [3:0] awcache, arcache, awregion, arregion, awqos, arqos, wstrb;
  logic [9:0] awuser, aruser, wuser;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [31:0] rdata = 0;
  int checks = 0, errors = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  always #5 clk = ~clk;

  apb2axi dut (
    .ACLK(clk), .ARESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB2AXI_APB4_EN
    .PSTRB(pstrb), .PPROT(pprot),
`endif
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWSIZE(awsize), .AWBURST(awburst),
    .AWLOCK(awlock), .AWCACHE(awcache), .AWPROT(awprot), .AWREGION(awregion), .AWQOS(awqos),
    .AWUSER(awuser), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WLAST(wlast), .WUSER(wuser), .WVALID(wvalid), .WREADY(wready),
    .BID(16'h0), .BRESP(bresp), .BUSER(10'h0), .BVALID(bvalid), .BREADY(bready),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARSIZE(arsize), .ARBURST(arburst),
    .ARLOCK(arlock), .ARCACHE(arcache), .ARPROT(arprot), .ARREGION(arregion), .ARQOS(arqos),
    .ARUSER(aruser), .ARVALID(arvalid), .ARREADY(arready),
    .RID(16'h0), .RDATA(rdata), .RRESP(rresp), .RLAST(1'b1), .RUSER(10'h0), .RVALID(rvalid),
    .RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd_slv(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : 32'h0;
  endfunction

  // One APB access with the AXI side stalled da/dw cycles on the request and db cycles on the response.
  // The access completes at cycle 3 + request stall + response stall relative to the setup cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input int da,
                      input int dw, input int db, input logic [1:0] resp, input int rst_at, input bit abort);
    int m, done_n;
    logic [31:0] exp_rd, aw_a, w_d, ar_a;
    logic [3:0] exp_strb, w_s;
    logic [2:0] exp_prot;
    m = wr ? ((da > dw) ? da : dw) : da;
    done_n = 3 + m + db;
    aw_a = 0; w_d = 0; w_s = 0; ar_a = 0;
    pstrb = 4'($urandom);
    pprot = 3'($urandom);
`ifdef APB2AXI_APB4_EN
    exp_strb = pstrb;
    exp_prot = pprot;
`else
    exp_strb = 4'hf;
    exp_prot = 3'd0;
`endif
    if (wr) ref_mem[a] = merge(rd_ref(a), d, exp_strb);
    exp_rd = rd_ref(a);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    for (int n = 1; n <= done_n; n++) begin
      if (abort && n == 2) begin psel = 0; penable = 0; end
      awready = wr && n == 1 + da;
      wready = wr && n == 1 + dw;
      arready = !wr && n == 1 + da;
      bvalid = wr && n == 2 + m + db;
      bresp = resp;
      rvalid = !wr && n == 2 + m + db;
      rresp = resp;
      rdata = rvalid ? rd_slv(ar_a) : 32'h0;
      chk("pready", 32'(pready), 32'(n == done_n));
      if (wr) begin
        chk("awvalid", 32'(awvalid), 32'(n <= 1 + da));
        chk("wvalid", 32'(wvalid), 32'(n <= 1 + dw));
        chk("bready", 32'(bready), 32'(n >= 2 + m && n < done_n));
        chk("arvalid_wr", 32'(arvalid), 32'd0);
        if (n == 1 + da) begin
          chk("awaddr", awaddr, a);
          chk("awlen", 32'(awlen), 32'd0);
          chk("awsize", 32'(awsize), 32'd2);
          chk("awburst", 32'(awburst), 32'd1);
          chk("awprot", 32'(awprot), 32'(exp_prot));
          chk("awid", 32'(awid), 32'd0);
          aw_a = awaddr;
        end
        if (n == 1 + dw) begin
          chk("wdata", wdata, d);
          chk("wstrb", 32'(wstrb), 32'(exp_strb));
          chk("wlast", 32'(wlast), 32'd1);
          w_d = wdata; w_s = wstrb;
        end
        if (n == 1 + m) slv_mem[aw_a] = merge(rd_slv(aw_a), w_d, w_s);
      end else begin
        chk("arvalid", 32'(arvalid), 32'(n <= 1 + da));
        chk("rready", 32'(rready), 32'(n >= 2 + m && n < done_n));
        chk("awvalid_rd", 32'(awvalid), 32'd0);
        if (n == 1 + da) begin
          chk("araddr", araddr, a);
          chk("arlen", 32'(arlen), 32'd0);
          chk("arprot", 32'(arprot), 32'(exp_prot));
          ar_a = araddr;
        end
      end
      if (n == done_n) begin
        chk("pslverr", 32'(pslverr), 32'(resp[1]));
        chk("prdata", prdata, wr ? 32'h0 : exp_rd);
      end else chk("pslverr_idle", 32'(pslverr), 32'd0);
      if (rst_at == n) rst = 1;
      @(posedge clk); #1;
      if (rst_at == n) begin
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, rready}), 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        rst = 0;
        break;
      end
    end
    psel = 0; penable = 0;
    {awready, wready, arready, bvalid, rvalid} = '0;
    chk("pready_once", 32'(pready), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
    chk("reset_pready", 32'(pready), 32'd0);
    chk("reset_pslverr", 32'(pslverr), 32'd0);
    chk("reset_prdata", prdata, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    xfer(1, 32'h1000_0040, 32'hDEAD_BEEF, 0, 0, 0, 2'b00, -1, 0);
    ref_mem[32'h2000_0000] = 32'h1234_5678;
    slv_mem[32'h2000_0000] = 32'h1234_5678;
    xfer(0, 32'h2000_0000, 32'h0, 0, 0, 5, 2'b00, -1, 0);
    xfer(1, 32'h1000_0044, 32'hCAFE_F00D, 3, 0, 0, 2'b00, -1, 0);
    xfer(0, 32'h1000_0040, 32'h0, 0, 0, 0, 2'b11, -1, 0);
    xfer(0, 32'h1000_0044, 32'h0, 0, 0, 0, 2'b00, -1, 0);
    xfer(1, 32'h1000_0048, 32'h0BAD_0BAD, 0, 0, 5, 2'b00, 2, 0);
    xfer(0, 32'h2000_0000, 32'h0, 0, 0, 0, 2'b00, -1, 0);
    xfer(1, 32'h1000_004C, 32'h5555_AAAA, 1, 2, 1, 2'b10, -1, 1);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h3000_0000 + 32'($urandom_range(0, 7) * 4);
      xfer(1'($urandom), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), 2'($urandom), -1, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
